// File: rtl/gate_sequencer_pkg.sv
// Shared definitions for the frequency-counter measurement sequencer.
//   seqState_t : sequencer state encoding (IDLE, CLEAR, GATE, HOLD, LATCH, DONE)
//   maxU       : larger of two unsigned values, used to size the shared timer
package gate_sequencer_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_GATE  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_LATCH = 3'd4,
    ST_DONE  = 3'd5
  } seqState_t;

  function automatic int unsigned maxU(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/gate_sequencer_timer.sv
// Loadable down-counter shared by the GATE and HOLD phases.
//   clkControl : clock
//   resetN     : synchronous active-low reset
//   load       : load counter with value (has priority over dec)
//   value      : load value
//   dec        : decrement by one; holds at zero (no wrap)
//   zero_c     : combinational decode, counter equals zero
module gate_sequencer_timer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clkControl,
  input  logic             resetN,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  input  logic             dec,
  output logic             zero_c
);

  logic [WIDTH-1:0] count;

  // Down-counter with load priority; saturates at zero.
  always_ff @(posedge clkControl) begin
    if (!resetN) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (dec && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero_c = (count == '0);

endmodule

// File: rtl/gate_sequencer.sv
// Measurement sequencer for the frequency-counter datapath. Produces the
// clear -> gate -> settle -> latch -> done strobe order with a start/busy/done
// handshake, single-shot or continuous, two gate lengths and source select.
//   clkControl  : clock, rising edge
//   resetN      : synchronous active-low reset
//   start       : request one measurement (sampled in IDLE only)
//   continuous  : auto-restart after DONE; also starts from IDLE
//   abort       : cancel a measurement in progress (no latch, no done)
//   modeControl : range select, 0 long gate / 1 short gate (snapshot at CLEAR)
//   testMode    : source select (snapshot at CLEAR)
//   overflow    : counter overflow flag from the datapath
//   enable      : count gate
//   clear       : one-cycle counter clear strobe
//   latch       : one-cycle result latch strobe
//   testSel     : testMode snapshot for the current/last measurement
//   rangeOut    : modeControl snapshot for the current/last measurement
//   busy        : high from CLEAR through DONE
//   done        : one-cycle result-valid pulse
//   ovfFlag     : overflow seen during the last completed gate
module gate_sequencer
  import gate_sequencer_pkg::*;
#(
  parameter int unsigned GATE_LONG   = 1000,
  parameter int unsigned GATE_SHORT  = 100,
  parameter int unsigned HOLD_CYCLES = 2
) (
  input  logic clkControl,
  input  logic resetN,
  input  logic start,
  input  logic continuous,
  input  logic abort,
  input  logic modeControl,
  input  logic testMode,
  input  logic overflow,
  output logic enable,
  output logic clear,
  output logic latch,
  output logic testSel,
  output logic rangeOut,
  output logic busy,
  output logic done,
  output logic ovfFlag
);

  // Timer must also hold HOLD_CYCLES-1 should it ever exceed the long gate.
  localparam int unsigned CNT_W = $clog2(maxU(GATE_LONG, HOLD_CYCLES) + 1);

  seqState_t        state;
  seqState_t        stateNext;
  logic             timerLoad;
  logic [CNT_W-1:0] timerValue;
  logic             timerDec;
  logic             timerZero;
  logic             ovfSeen;

  gate_sequencer_timer #(
    .WIDTH (CNT_W)
  ) uTimer (
    .clkControl (clkControl),
    .resetN     (resetN),
    .load       (timerLoad),
    .value      (timerValue),
    .dec        (timerDec),
    .zero_c     (timerZero)
  );

  // Next-state and timer control.
  always_comb begin
    stateNext  = state;
    timerLoad  = 1'b0;
    timerValue = '0;
    timerDec   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start || continuous) stateNext = ST_CLEAR;
      end
      ST_CLEAR: begin
        // Timer holds G-1 so GATE lasts exactly G cycles ending on zero.
        stateNext  = ST_GATE;
        timerLoad  = 1'b1;
        timerValue = rangeOut ? CNT_W'(GATE_SHORT - 1) : CNT_W'(GATE_LONG - 1);
      end
      ST_GATE: begin
        if (timerZero) begin
          stateNext  = ST_HOLD;
          timerLoad  = 1'b1;
          timerValue = CNT_W'(HOLD_CYCLES - 1);
        end else begin
          timerDec = 1'b1;
        end
      end
      ST_HOLD: begin
        if (timerZero) stateNext = ST_LATCH;
        else           timerDec  = 1'b1;
      end
      ST_LATCH: begin
        stateNext = ST_DONE;
      end
      ST_DONE: begin
        stateNext = continuous ? ST_CLEAR : ST_IDLE;
      end
      default: begin
        stateNext = ST_IDLE;
      end
    endcase
    // Abort overrides every transition out of a non-idle state.
    if (abort && (state != ST_IDLE)) begin
      stateNext = ST_IDLE;
      timerLoad = 1'b0;
      timerDec  = 1'b0;
    end
  end

  // State register and Moore outputs decoded from the state being entered.
  always_ff @(posedge clkControl) begin
    if (!resetN) begin
      state    <= ST_IDLE;
      enable   <= 1'b0;
      clear    <= 1'b0;
      latch    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      testSel  <= 1'b0;
      rangeOut <= 1'b0;
      ovfSeen  <= 1'b0;
      ovfFlag  <= 1'b0;
    end else begin
      state  <= stateNext;
      enable <= (stateNext == ST_GATE);
      clear  <= (stateNext == ST_CLEAR);
      latch  <= (stateNext == ST_LATCH);
      done   <= (stateNext == ST_DONE);
      busy   <= (stateNext != ST_IDLE);

      if (stateNext == ST_CLEAR) begin
        testSel  <= testMode;
        rangeOut <= modeControl;
      end

      // ovfSeen spans one gate; it is transferred to ovfFlag on entry to LATCH.
      if ((stateNext == ST_CLEAR) || (stateNext == ST_LATCH)) begin
        ovfSeen <= 1'b0;
      end else if ((state == ST_GATE) && overflow) begin
        ovfSeen <= 1'b1;
      end

      if (stateNext == ST_LATCH) begin
        ovfFlag <= ovfSeen;
      end
    end
  end

endmodule

// File: tb/tb_gate_sequencer.sv
// Scoreboard bench for gate_sequencer: stimulus pushes the expected strobe
// events (clear/latch/done with cycle and attributes), a negedge monitor pops
// and compares them as the DUT raises each strobe.
module tb_gate_sequencer;

  localparam int unsigned GL = 10;
  localparam int unsigned GS = 4;
  localparam int unsigned HC = 2;

  logic clkControl = 1'b0;
  logic resetN, start, continuous, abort, modeControl, testMode, overflow;
  logic enable, clear, latch, testSel, rangeOut, busy, done, ovfFlag;

  always #5 clkControl = ~clkControl;

  gate_sequencer #(
    .GATE_LONG   (GL),
    .GATE_SHORT  (GS),
    .HOLD_CYCLES (HC)
  ) dut (
    .clkControl  (clkControl),
    .resetN      (resetN),
    .start       (start),
    .continuous  (continuous),
    .abort       (abort),
    .modeControl (modeControl),
    .testMode    (testMode),
    .overflow    (overflow),
    .enable      (enable),
    .clear       (clear),
    .latch       (latch),
    .testSel     (testSel),
    .rangeOut    (rangeOut),
    .busy        (busy),
    .done        (done),
    .ovfFlag     (ovfFlag)
  );

  typedef struct {
    int   kind;     // 0 clear, 1 latch, 2 done
    int   cyc;
    int   gateLen;
    logic rng;
    logic tst;
    logic ovf;
  } ev_t;

  ev_t expQ[$];
  ev_t monEv;
  int  tests = 0;
  int  fails = 0;
  int  cyc = 0;
  int  enCount = 0;
  int  busyCount = 0;
  int  actKind;

  always @(posedge clkControl) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Monitor: track gate/busy lengths and score every strobe against the queue.
  always @(negedge clkControl) begin
    if (clear) begin
      enCount   = 0;
      busyCount = 0;
    end
    if (enable) enCount++;
    if (busy)   busyCount++;
    if (clear || latch || done) begin
      actKind = clear ? 0 : (latch ? 1 : 2);
      if (expQ.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_strobe at cycle %0d: got kind %0d, expected none", cyc, actKind);
      end else begin
        monEv = expQ.pop_front();
        check("strobe_onehot", 32'(clear) + 32'(latch) + 32'(done), 32'd1);
        check("strobe_kind", 32'(actKind), 32'(monEv.kind));
        check("strobe_cycle", 32'(cyc), 32'(monEv.cyc));
        case (actKind)
          0: begin
            check("clear_busy", 32'(busy), 32'd1);
            check("clear_range", 32'(rangeOut), 32'(monEv.rng));
            check("clear_testsel", 32'(testSel), 32'(monEv.tst));
          end
          1: begin
            check("latch_gate_len", 32'(enCount), 32'(monEv.gateLen));
            check("latch_ovf", 32'(ovfFlag), 32'(monEv.ovf));
            check("latch_enable_low", 32'(enable), 32'd0);
          end
          default: begin
            check("done_busy_len", 32'(busyCount), 32'(monEv.gateLen + int'(HC) + 3));
            check("done_ovf", 32'(ovfFlag), 32'(monEv.ovf));
            check("done_range", 32'(rangeOut), 32'(monEv.rng));
            check("done_testsel", 32'(testSel), 32'(monEv.tst));
          end
        endcase
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clkControl);
    #1;
  endtask

  task automatic pushEv(input int kind, input int c, input int g, input logic r, input logic t, input logic o);
    ev_t e;
    e.kind = kind; e.cyc = c; e.gateLen = g; e.rng = r; e.tst = t; e.ovf = o;
    expQ.push_back(e);
  endtask

  // Full run started (start/continuous sampled) at the end of cycle b.
  task automatic expectRun(input int b, input int g, input logic r, input logic t, input logic o);
    pushEv(0, b + 1, g, r, t, o);
    pushEv(1, b + 2 + g + int'(HC), g, r, t, o);
    pushEv(2, b + 3 + g + int'(HC), g, r, t, o);
  endtask

  // Order: {enable, clear, latch, testSel, rangeOut, busy, done, ovfFlag}
  task automatic checkOuts(input string name, input logic [7:0] expv);
    @(negedge clkControl);
    check(name, 32'({enable, clear, latch, testSel, rangeOut, busy, done, ovfFlag}), 32'(expv));
  endtask

  task automatic waitDrain(input string name);
    int n = 0;
    while ((expQ.size() != 0) && (n < 200)) begin
      tick(1);
      n++;
    end
    check({name, "_drained"}, 32'(expQ.size()), 32'd0);
    expQ.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog at cycle %0d: got timeout, expected completion", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int b;
    resetN = 1'b0; start = 1'b0; continuous = 1'b0; abort = 1'b0;
    modeControl = 1'b0; testMode = 1'b0; overflow = 1'b0;
    tick(3);
    checkOuts("reset_state", 8'b0000_0000);
    resetN = 1'b1;
    tick(2);

    // 1: long gate, single shot
    b = cyc;
    start = 1'b1;
    expectRun(b, GL, 1'b0, 1'b0, 1'b0);
    tick(1); start = 1'b0;
    tick(15);
    checkOuts("s1_idle", 8'b0000_0000);
    waitDrain("s1");

    // 2: short gate, snapshot holds despite toggle, start while busy ignored
    tick(1);
    b = cyc;
    modeControl = 1'b1; testMode = 1'b1; start = 1'b1;
    expectRun(b, GS, 1'b1, 1'b1, 1'b0);
    tick(1); start = 1'b0;
    tick(2); modeControl = 1'b0;
    tick(2); start = 1'b1;
    tick(1); start = 1'b0;
    tick(4);
    checkOuts("s2_idle", 8'b0001_1000);
    testMode = 1'b0;
    waitDrain("s2");

    // 3: continuous, dropped mid second run
    tick(1);
    b = cyc;
    continuous = 1'b1;
    expectRun(b, GL, 1'b0, 1'b0, 1'b0);
    expectRun(b + 15, GL, 1'b0, 1'b0, 1'b0);
    tick(20); continuous = 1'b0;
    tick(11);
    checkOuts("s3_idle", 8'b0000_0000);
    waitDrain("s3");

    // 4: overflow pulse mid-gate
    tick(1);
    b = cyc;
    start = 1'b1;
    expectRun(b, GL, 1'b0, 1'b0, 1'b1);
    tick(1); start = 1'b0;
    tick(5); overflow = 1'b1;
    tick(1); overflow = 1'b0;
    tick(9);
    checkOuts("s4_ovf_hold", 8'b0000_0001);
    waitDrain("s4");

    // 5: abort mid-gate keeps ovfFlag, clean restart then reports no overflow
    tick(1);
    b = cyc;
    start = 1'b1;
    pushEv(0, b + 1, GL, 1'b0, 1'b0, 1'b1);
    tick(1); start = 1'b0;
    tick(6); abort = 1'b1;
    tick(1); abort = 1'b0;
    checkOuts("s5_abort", 8'b0000_0001);
    tick(2);
    b = cyc;
    start = 1'b1;
    expectRun(b, GL, 1'b0, 1'b0, 1'b0);
    tick(1); start = 1'b0;
    tick(12);
    checkOuts("s5_ovf_before_latch", 8'b0000_0101);
    tick(3);
    checkOuts("s5_idle", 8'b0000_0000);
    waitDrain("s5");

    // 6: reset mid-gate, start while busy
    tick(1);
    b = cyc;
    testMode = 1'b1; start = 1'b1;
    pushEv(0, b + 1, GL, 1'b0, 1'b1, 1'b0);
    tick(1); start = 1'b0;
    tick(4); start = 1'b1;
    tick(1); start = 1'b0;
    tick(3); resetN = 1'b0;
    tick(1);
    checkOuts("s6_reset", 8'b0000_0000);
    resetN = 1'b1; testMode = 1'b0;
    tick(2);
    waitDrain("s6");

    // 7: abort is ignored in IDLE; start with abort high still launches a short run
    tick(1);
    b = cyc;
    modeControl = 1'b1; start = 1'b1; abort = 1'b1;
    expectRun(b, GS, 1'b1, 1'b0, 1'b0);
    tick(1); start = 1'b0; abort = 1'b0;
    tick(9);
    checkOuts("s7_idle", 8'b0000_1000);
    waitDrain("s7");

    tick(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
